execute: RTL

EXECUTE -- requirements
Module: execute

---
 rtl/kasumi_pkg.sv | 101 ++++++++++
 rtl/execute_if.sv | 43 ++++
 rtl/div_iter.sv | 101 ++++++++++
 rtl/execute.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/kasumi_pkg.sv
// ----------------------------------------------------------------------------
// kasumi_pkg
// Shared encodings for the execute stage: instruction class codes, the
// funct7 value that selects RV32M, mem_command bit meanings, funct3 names
// and the execute FSM states. Also holds the small pure helpers for the
// integer ALU and the branch comparator so the top stays readable.
// ----------------------------------------------------------------------------
package kasumi_pkg;

    // Instruction class carried in ex_command[5:3]
    typedef enum logic [2:0] {
        CLASS_IMM    = 3'b000,
        CLASS_REG    = 3'b001,
        CLASS_BRANCH = 3'b010,
        CLASS_MULDIV = 3'b011,
        CLASS_JUMP   = 3'b100,
        CLASS_SYSTEM = 3'b101,
        CLASS_FENCE  = 3'b110
    } exClass_e;

    // Execute stage sequencing: single-cycle work happens in IDLE,
    // DIV covers the whole iterative divide.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } exState_e;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // mem_command layout: [0] access, [1] write, [1:0]=10 CSR, [4:2] funct3
    localparam int         MEM_ACCESS_BIT = 0;
    localparam int         MEM_WRITE_BIT  = 1;
    localparam logic [1:0] MEM_CSR        = 2'b10;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // RV32M funct3 (funct3[2]=1 selects the divider, funct3[1]=1 remainder)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // Jump funct3
    localparam logic [2:0] F3_JAL  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b001;

    // Integer ALU. subSel turns add into sub, sraSel makes the right
    // shift arithmetic; only the low five bits of b shift.
    function automatic logic [31:0] aluOp(input logic [2:0]  f3,
                                          input logic        subSel,
                                          input logic        sraSel,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            F3_ADD:  r = subSel ? (a - b) : (a + b);
            F3_SLL:  r = a << b[4:0];
            F3_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
            F3_SLTU: r = {31'b0, (a < b)};
            F3_XOR:  r = a ^ b;
            F3_SR:   r = sraSel ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            F3_OR:   r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Branch condition; the two unused funct3 codes never branch.
    function automatic logic branchCond(input logic [2:0]  f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic t;
        case (f3)
            F3_BEQ:  t = (a == b);
            F3_BNE:  t = (a != b);
            F3_BLT:  t = ($signed(a) <  $signed(b));
            F3_BGE:  t = ($signed(a) >= $signed(b));
            F3_BLTU: t = (a <  b);
            F3_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/execute_if.sv
// ----------------------------------------------------------------------------
// execute_if
// Bundle between decode, execute and the memory stage.
//   Decode side : stop, mem_command, ex_command, ex_command_f7, data_0,
//                 data_1, mem_write_data, reg_d, in_now_pc
//   Result side : out_mem_command, out_reg_d, out_result, out_mem_write_data,
//                 out_now_pc, branch_taken, branch_target, busy
// slave is the execute stage, master is whoever drives decode fields.
// ----------------------------------------------------------------------------
interface execute_if;
    logic        stop;
    logic [4:0]  mem_command;
    logic [5:0]  ex_command;
    logic [6:0]  ex_command_f7;
    logic [31:0] data_0;
    logic [31:0] data_1;
    logic [31:0] mem_write_data;
    logic [4:0]  reg_d;
    logic [31:0] in_now_pc;

    logic [4:0]  out_mem_command;
    logic [4:0]  out_reg_d;
    logic [31:0] out_result;
    logic [31:0] out_mem_write_data;
    logic [31:0] out_now_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        busy;

    modport slave (
        input  stop, mem_command, ex_command, ex_command_f7, data_0, data_1,
               mem_write_data, reg_d, in_now_pc,
        output out_mem_command, out_reg_d, out_result, out_mem_write_data,
               out_now_pc, branch_taken, branch_target, busy
    );

    modport master (
        output stop, mem_command, ex_command, ex_command_f7, data_0, data_1,
               mem_write_data, reg_d, in_now_pc,
        input  out_mem_command, out_reg_d, out_result, out_mem_write_data,
               out_now_pc, branch_taken, branch_target, busy
    );
endinterface

// File: rtl/div_iter.sv
// ----------------------------------------------------------------------------
// div_iter
// 32-iteration restoring divider working on magnitudes, with sign fix-up
// and divide-by-zero handling applied on the way out.
//   clk, rst_n    : clock, async active-low reset (aborts any divide)
//   hold_i        : freezes all state
//   start_i       : load operands and begin (ignored while hold_i)
//   signed_i      : treat operands as two's complement
//   dividend_i,
//   divisor_i     : operands sampled on the start edge
//   done_o        : high for the edge after the last iteration
//   quotient_o,
//   remainder_o   : final results, valid while done_o
// ----------------------------------------------------------------------------
module div_iter
    import kasumi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic        active_q;
    logic [5:0]  count_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] divisorMag_q;
    logic [31:0] dividend_q;
    logic        negQuo_q;
    logic        negRem_q;
    logic        divZero_q;

    logic [31:0] dividendMag;
    logic [31:0] divisorMag;
    logic [32:0] remShift;
    logic [32:0] remDiff;

    assign dividendMag = (signed_i && dividend_i[31]) ? (32'd0 - dividend_i) : dividend_i;
    assign divisorMag  = (signed_i && divisor_i[31])  ? (32'd0 - divisor_i)  : divisor_i;

    // Dividend bits enter the partial remainder from the top of quo_q;
    // a clear borrow bit means the trial subtraction fits.
    assign remShift = {rem_q, quo_q[31]};
    assign remDiff  = remShift - {1'b0, divisorMag_q};

    // On start the dividend magnitude parks in quo_q and shifts out as
    // quotient bits shift in. After count reaches zero the divider stays
    // active for one more edge so the owner can take the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= 1'b0;
            count_q      <= 6'd0;
            rem_q        <= 32'd0;
            quo_q        <= 32'd0;
            divisorMag_q <= 32'd0;
            dividend_q   <= 32'd0;
            negQuo_q     <= 1'b0;
            negRem_q     <= 1'b0;
            divZero_q    <= 1'b0;
        end else if (!hold_i) begin
            if (start_i) begin
                active_q     <= 1'b1;
                count_q      <= 6'd32;
                rem_q        <= 32'd0;
                quo_q        <= dividendMag;
                divisorMag_q <= divisorMag;
                dividend_q   <= dividend_i;
                negQuo_q     <= signed_i && (dividend_i[31] ^ divisor_i[31]);
                negRem_q     <= signed_i && dividend_i[31];
                divZero_q    <= (divisor_i == 32'd0);
            end else if (active_q) begin
                if (count_q != 6'd0) begin
                    count_q <= count_q - 6'd1;
                    if (!remDiff[32]) begin
                        rem_q <= remDiff[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= remShift[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                end else begin
                    active_q <= 1'b0;
                end
            end
        end
    end

    // Divide by zero bypasses the sign fix-up: all-ones quotient and the
    // untouched dividend. The signed overflow case falls out naturally.
    assign done_o      = active_q && (count_q == 6'd0);
    assign quotient_o  = divZero_q ? 32'hFFFF_FFFF : (negQuo_q ? (32'd0 - quo_q) : quo_q);
    assign remainder_o = divZero_q ? dividend_q    : (negRem_q ? (32'd0 - rem_q) : rem_q);

endmodule

// File: rtl/execute.sv
// ----------------------------------------------------------------------------
// execute
// RV32IM execute stage. Single-cycle ALU, multiply, branch and jump work
// register their results on the capture edge; divides hand off to div_iter
// and hold busy until the result is driven.
//   clk, rst_n : clock, async active-low reset
//   bus        : execute_if.slave, decode fields in, registered results out
// ----------------------------------------------------------------------------
module execute
    import kasumi_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    execute_if.slave bus
);

    exClass_e    exClass;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        isMulDiv;
    logic        isDivOp;
    logic [63:0] mulA;
    logic [63:0] mulB;
    logic [63:0] product;
    logic [31:0] mulResult;

    logic [31:0] result_d;
    logic [31:0] target_d;
    logic        taken_d;
    logic        bubble_d;

    exState_e    state_q;
    logic        squash_q;
    logic [4:0]  outMemCmd_q;
    logic [4:0]  outRegD_q;
    logic [31:0] outResult_q;
    logic [31:0] outMemWData_q;
    logic [31:0] outPc_q;
    logic        taken_q;
    logic [31:0] target_q;
    logic [4:0]  pendMemCmd_q;
    logic [4:0]  pendRegD_q;
    logic        pendRem_q;

    logic        divStart;
    logic        divDone;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign exClass  = exClass_e'(bus.ex_command[5:3]);
    assign funct3   = bus.ex_command[2:0];
    assign funct7   = bus.ex_command_f7;
    assign isMulDiv = (exClass == CLASS_MULDIV) ||
                      ((exClass == CLASS_REG) && (funct7 == F7_MULDIV));
    assign isDivOp  = isMulDiv && funct3[2];

    // One 64-bit multiplier; extending each operand as signed or unsigned
    // picks mulh/mulhsu/mulhu, and the low word is the same for all.
    assign mulA      = (funct3 == F3_MULHU) ? {32'b0, bus.data_0} : {{32{bus.data_0[31]}}, bus.data_0};
    assign mulB      = ((funct3 == F3_MULHSU) || (funct3 == F3_MULHU)) ?
                       {32'b0, bus.data_1} : {{32{bus.data_1[31]}}, bus.data_1};
    assign product   = mulA * mulB;
    assign mulResult = (funct3 == F3_MUL) ? product[31:0] : product[63:32];

    // Next-state values for a normal single-cycle capture.
    always_comb begin
        result_d = 32'd0;
        target_d = 32'd0;
        taken_d  = 1'b0;
        bubble_d = 1'b0;
        case (exClass)
            CLASS_IMM: begin
                result_d = aluOp(funct3, 1'b0, funct7[5], bus.data_0, bus.data_1);
            end
            CLASS_REG: begin
                if (isMulDiv) begin
                    result_d = mulResult;
                end else begin
                    result_d = aluOp(funct3, funct7[5], funct7[5], bus.data_0, bus.data_1);
                end
            end
            CLASS_MULDIV: begin
                result_d = mulResult;
            end
            CLASS_BRANCH: begin
                taken_d  = branchCond(funct3, bus.data_0, bus.data_1);
                target_d = taken_d ? (bus.in_now_pc + bus.mem_write_data) : 32'd0;
            end
            CLASS_JUMP: begin
                result_d = bus.in_now_pc + 32'd4;
                taken_d  = 1'b1;
                target_d = (funct3 == F3_JALR) ? ((bus.data_0 + bus.data_1) & ~32'd1)
                                               : (bus.in_now_pc + bus.data_1);
            end
            CLASS_SYSTEM: begin
                result_d = bus.data_0;
            end
            default: begin
                bubble_d = 1'b1;
            end
        endcase
    end

    assign divStart = (state_q == ST_IDLE) && !squash_q && isDivOp;

    div_iter u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold_i      (bus.stop),
        .start_i     (divStart),
        .signed_i    (~funct3[0]),
        .dividend_i  (bus.data_0),
        .divisor_i   (bus.data_1),
        .done_o      (divDone),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    // Stage FSM. stop freezes everything including the squash flag. In
    // IDLE every non-stopped edge captures; the instruction right after a
    // redirect is squashed because it came from the wrong path. A divide
    // emits a bubble on capture and its result once div_iter finishes;
    // inputs are ignored throughout DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            squash_q      <= 1'b0;
            outMemCmd_q   <= 5'd0;
            outRegD_q     <= 5'd0;
            outResult_q   <= 32'd0;
            outMemWData_q <= 32'd0;
            outPc_q       <= 32'd0;
            taken_q       <= 1'b0;
            target_q      <= 32'd0;
            pendMemCmd_q  <= 5'd0;
            pendRegD_q    <= 5'd0;
            pendRem_q     <= 1'b0;
        end else if (!bus.stop) begin
            case (state_q)
                ST_IDLE: begin
                    outPc_q       <= bus.in_now_pc;
                    outMemWData_q <= bus.mem_write_data;
                    if (squash_q || bubble_d || isDivOp) begin
                        outMemCmd_q <= 5'd0;
                        outRegD_q   <= 5'd0;
                        outResult_q <= 32'd0;
                        taken_q     <= 1'b0;
                        target_q    <= 32'd0;
                        squash_q    <= 1'b0;
                        if (!squash_q && isDivOp) begin
                            state_q      <= ST_DIV;
                            pendMemCmd_q <= bus.mem_command;
                            pendRegD_q   <= bus.reg_d;
                            pendRem_q    <= funct3[1];
                        end
                    end else begin
                        outMemCmd_q <= bus.mem_command;
                        outRegD_q   <= bus.reg_d;
                        outResult_q <= result_d;
                        taken_q     <= taken_d;
                        target_q    <= target_d;
                        squash_q    <= taken_d;
                    end
                end
                ST_DIV: begin
                    if (divDone) begin
                        state_q     <= ST_IDLE;
                        outMemCmd_q <= pendMemCmd_q;
                        outRegD_q   <= pendRegD_q;
                        outResult_q <= pendRem_q ? remainder : quotient;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_mem_command    = outMemCmd_q;
    assign bus.out_reg_d          = outRegD_q;
    assign bus.out_result         = outResult_q;
    assign bus.out_mem_write_data = outMemWData_q;
    assign bus.out_now_pc         = outPc_q;
    assign bus.branch_taken       = taken_q;
    assign bus.branch_target      = target_q;
    assign bus.busy               = (state_q == ST_DIV);

endmodule
